// File: rtl/dma_controller_if.sv
// dma_controller_if: CPU command, bus arbitration, device
// slot and memory burst signals of the DMA engine.
interface dma_controller_if #(
   parameter int WORD_SIZE      = 16,
   parameter int DEVICE_BIT_LEN = 2
);
   logic                      cmd_valid;
   logic [WORD_SIZE-1:0]      cmd_addr;
   logic [WORD_SIZE-1:0]      cmd_length;
   logic                      bg;
   logic                      br;
   logic [DEVICE_BIT_LEN-1:0] offset;
   logic [4*WORD_SIZE-1:0]    dev_data;
   wire  [WORD_SIZE-1:0]      mem_addr;
   wire  [4*WORD_SIZE-1:0]    mem_data;
   logic                      mem_write;
   logic                      mem_ready;
   logic                      dma_end;
   logic                      busy;

   modport master (
      input  cmd_valid, cmd_addr, cmd_length,
      input  bg, dev_data, mem_ready,
      output br, offset, mem_addr, mem_data,
      output mem_write, dma_end, busy
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_length,
      output bg, dev_data, mem_ready,
      input  br, offset, mem_addr, mem_data,
      input  mem_write, dma_end, busy
   );
endinterface

// File: rtl/dma_controller.sv
// dma_controller: bus-mastering engine copying device slots
// into data memory as 4-word bursts, one slot per chunk.
module dma_controller #(
   parameter int WORD_SIZE      = 16,
   parameter int DATA_SIZE      = 3,
   parameter int DEVICE_BIT_LEN = 2
) (
   input logic              clk,
   input logic              reset_n,
   dma_controller_if.master bus
);
   localparam int CW = $clog2(DATA_SIZE + 1);
   localparam int LW = WORD_SIZE - 2;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      FETCH,
      WRITE,
      DONE
   } state_t;

   state_t                    state;
   state_t                    state_n;
   logic [WORD_SIZE-1:0]      base;
   logic [CW-1:0]             chunks;
   logic [CW-1:0]             chunks_cmd;
   logic [CW-1:0]             idx;
   logic [CW-1:0]             idx_inc;
   logic [4*WORD_SIZE-1:0]    data_q;
   logic [DEVICE_BIT_LEN-1:0] offset_q;
   logic [LW-1:0]             len_bursts;
   logic                      accept;
   logic                      grant_go;
   logic                      capture;
   logic                      advance;
   logic                      last;
   logic                      wr_en;
   logic                      unused_len;

   // low two length bits never form a full burst
   assign unused_len = ^bus.cmd_length[1:0];
   assign len_bursts = bus.cmd_length[WORD_SIZE-1:2];

   always_comb begin
      chunks_cmd = CW'(DATA_SIZE);
      if (len_bursts < LW'(DATA_SIZE))
         chunks_cmd = CW'(len_bursts);
   end

   assign idx_inc  = idx + CW'(1);
   assign last     = (idx_inc == chunks);
   assign accept   = (state == IDLE) && bus.cmd_valid;
   assign grant_go = (state == REQ) && bus.bg;
   assign capture  = (state == FETCH) && bus.bg;
   assign wr_en    = (state == WRITE) && bus.bg;
   assign advance  = wr_en && bus.mem_ready;

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (bus.cmd_valid)
               state_n = (chunks_cmd == '0) ? DONE : REQ;
         end
         REQ: begin
            if (bus.bg)
               state_n = FETCH;
         end
         FETCH: begin
            if (bus.bg)
               state_n = WRITE;
         end
         WRITE: begin
            if (advance)
               state_n = last ? DONE : FETCH;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base     <= '0;
         chunks   <= '0;
         idx      <= '0;
         offset_q <= '0;
         data_q   <= '0;
      end else begin
         if (accept) begin
            base   <= bus.cmd_addr;
            chunks <= chunks_cmd;
            idx    <= '0;
         end
         if (grant_go)
            offset_q <= DEVICE_BIT_LEN'(idx);
         // slot is sampled once; a grant gap keeps it
         if (capture)
            data_q <= bus.dev_data;
         if (advance) begin
            idx <= idx_inc;
            if (!last)
               offset_q <= DEVICE_BIT_LEN'(idx_inc);
         end
      end
   end

   assign bus.br = (state == REQ) || (state == FETCH) ||
                   (state == WRITE);
   assign bus.offset    = offset_q;
   assign bus.mem_write = wr_en;
   assign bus.mem_addr  = wr_en ?
      base + (WORD_SIZE'(idx) << 2) : 'z;
   assign bus.mem_data  = wr_en ? data_q : 'z;
   assign bus.dma_end   = (state == DONE);
   assign bus.busy      = (state != IDLE);
endmodule
